// File: rtl/bitty_pkg.sv
// Shared definitions for the parametrised Bitty core: instruction layout,
// ALU opcodes, operand formats and FSM state encoding.
package bitty_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned IMM_W   = 8;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned FMT_W   = 2;

    // Field LSB positions; imm8 overlaps ry and the pad bits
    localparam int unsigned RX_LSB  = 13;
    localparam int unsigned RY_LSB  = 10;
    localparam int unsigned IMM_LSB = 5;
    localparam int unsigned OP_LSB  = 2;
    localparam int unsigned FMT_LSB = 0;

    localparam logic [FMT_W-1:0] FMT_REG = 2'b00;
    localparam logic [FMT_W-1:0] FMT_IMM = 2'b01;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SHL = 3'd5,
        ALU_SHR = 3'd6,
        ALU_CMP = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

endpackage

// File: rtl/bitty_alu_p.sv
// Combinational Bitty ALU: unsigned arithmetic/logic/shift/compare with a
// carry (add) or borrow (sub) output.
module bitty_alu_p
    import bitty_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] y,
    output logic              carry
);

    localparam int unsigned SH_W = $clog2(DATA_W);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    logic [SH_W-1:0] sh;

    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} - {1'b0, b};
        sh    = b[SH_W-1:0];
        y     = '0;
        carry = 1'b0;
        case (op)
            ALU_ADD: begin
                y     = sum[DATA_W-1:0];
                carry = sum[DATA_W];
            end
            // Top bit of the widened difference is the borrow (a < b)
            ALU_SUB: begin
                y     = diff[DATA_W-1:0];
                carry = diff[DATA_W];
            end
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SHL: y = a << sh;
            ALU_SHR: y = a >> sh;
            ALU_CMP: begin
                if (a == b)     y = '0;
                else if (a > b) y = DATA_W'(1);
                else            y = DATA_W'(2);
            end
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/bitty_core_p.sv
// Parametrised Bitty core: one instruction per IDLE->LOAD->EXEC->WB pass,
// with flags, illegal-instruction reporting and a debug register read port.
module bitty_core_p
    import bitty_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               done,
    output logic               err,
    output logic [DATA_W-1:0]  result,
    output logic               flag_z,
    output logic               flag_c,
    input  logic [IDX_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    localparam int unsigned RA_W   = $clog2(NUM_REGS);
    localparam int unsigned IDXE_W = IDX_W + 1;
    localparam logic [IDX_W:0] NREG = IDXE_W'(NUM_REGS);

    state_e              state;
    state_e              state_next;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [DATA_W-1:0]   reg_s;
    logic [DATA_W-1:0]   reg_c;
    logic                illegal;

    logic                accept;
    logic                load_en;
    logic                exec_en;
    logic                wb_en;

    logic [IDX_W-1:0]    rx;
    logic [IDX_W-1:0]    ry;
    logic [IMM_W-1:0]    imm8;
    logic [FMT_W-1:0]    fmt;
    alu_op_e             op;
    logic [RA_W-1:0]     rx_i;
    logic [RA_W-1:0]     ry_i;
    logic                illegal_c;
    logic [DATA_W-1:0]   opnd_b;
    logic [DATA_W-1:0]   alu_y;
    logic                alu_carry;

    // Decode from the latched instruction
    assign rx   = ir[RX_LSB +: IDX_W];
    assign ry   = ir[RY_LSB +: IDX_W];
    assign imm8 = ir[IMM_LSB +: IMM_W];
    assign fmt  = ir[FMT_LSB +: FMT_W];
    assign op   = alu_op_e'(ir[OP_LSB +: OP_W]);
    assign rx_i = rx[RA_W-1:0];
    assign ry_i = ry[RA_W-1:0];

    assign illegal_c = fmt[1]
                     | ({1'b0, rx} >= NREG)
                     | ((fmt == FMT_REG) && ({1'b0, ry} >= NREG));

    // Registers only change in WB, so reading ry during EXEC still sees the
    // pre-instruction value even when rx == ry.
    assign opnd_b = (fmt == FMT_IMM) ? DATA_W'(imm8) : regs[ry_i];

    bitty_alu_p #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a     (reg_s),
        .b     (opnd_b),
        .op    (op),
        .y     (alu_y),
        .carry (alu_carry)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        load_en    = 1'b0;
        exec_en    = 1'b0;
        wb_en      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (instr_valid) begin
                    accept     = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_en    = 1'b1;
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                exec_en    = 1'b1;
                state_next = ST_WB;
            end
            ST_WB: begin
                wb_en      = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Illegal instructions still walk to WB but touch no architectural state
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            instr_ready <= 1'b1;
            ir          <= '0;
            reg_s       <= '0;
            reg_c       <= '0;
            illegal     <= 1'b0;
            flag_z      <= 1'b0;
            flag_c      <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            regs        <= '{default: '0};
        end else begin
            state       <= state_next;
            instr_ready <= (state_next == ST_IDLE);
            done        <= wb_en;
            err         <= wb_en & illegal;
            if (accept) begin
                ir <= instr;
            end
            if (load_en) begin
                reg_s   <= regs[rx_i];
                illegal <= illegal_c;
            end
            if (exec_en && !illegal) begin
                reg_c  <= alu_y;
                flag_z <= (alu_y == '0);
                flag_c <= alu_carry;
            end
            if (wb_en && !illegal) begin
                regs[rx_i] <= reg_c;
            end
        end
    end

    assign result   = reg_c;
    assign dbg_data = ({1'b0, dbg_addr} >= NREG) ? '0 : regs[dbg_addr[RA_W-1:0]];

endmodule

// File: tb/tb_bitty_core_p.sv
// Self-checking bench: two Bitty cores (16-bit/8 regs and 8-bit/4 regs) run
// in lockstep on the same stimulus and are compared against an arithmetic model.
module tb_bitty_core_p;
    import bitty_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic [2:0]  dbg_addr;

    logic        rdy_a, done_a, err_a, z_a, c_a;
    logic [15:0] res_a, dbg_a;
    logic        rdy_b, done_b, err_b, z_b, c_b;
    logic [7:0]  res_b, dbg_b;

    longint unsigned m_regs [2][8];
    longint unsigned m_res  [2];
    bit              m_z    [2];
    bit              m_c    [2];
    bit              m_err  [2];
    int              dw     [2] = '{16, 8};
    int              nr     [2] = '{8, 4};

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bitty_core_p #(.DATA_W(16), .NUM_REGS(8)) dut_a (
        .clk(clk), .reset(rst_n), .instr_valid(instr_valid), .instr_ready(rdy_a),
        .instr(instr), .done(done_a), .err(err_a), .result(res_a),
        .flag_z(z_a), .flag_c(c_a), .dbg_addr(dbg_addr), .dbg_data(dbg_a)
    );

    bitty_core_p #(.DATA_W(8), .NUM_REGS(4)) dut_b (
        .clk(clk), .reset(rst_n), .instr_valid(instr_valid), .instr_ready(rdy_b),
        .instr(instr), .done(done_b), .err(err_b), .result(res_b),
        .flag_z(z_b), .flag_c(c_b), .dbg_addr(dbg_addr), .dbg_data(dbg_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk_i(input logic [2:0] op, input logic [2:0] rx, input logic [7:0] imm);
        return {rx, imm, op, 2'b01};
    endfunction

    function automatic logic [15:0] mk_r(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry);
        return {rx, ry, 5'b00000, op, 2'b00};
    endfunction

    function automatic logic [15:0] rnd_instr();
        logic [15:0] v;
        v = 16'($urandom);
        if ($urandom_range(0, 7) != 0) v[1] = 1'b0;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) m_regs[k][i] = 0;
            m_res[k] = 0; m_z[k] = 0; m_c[k] = 0; m_err[k] = 0;
        end
    endtask

    // Architectural effect of one instruction on configuration k
    task automatic model_exec(input int k, input logic [15:0] ins);
        int rx, ry, op, sh, sw;
        longint unsigned a, b, r, mask;
        bit c;
        rx   = int'(ins[15:13]);
        ry   = int'(ins[12:10]);
        op   = int'(ins[4:2]);
        mask = (64'd1 << dw[k]) - 64'd1;
        m_err[k] = ins[1] || (rx >= nr[k]) || (ins[1:0] == 2'b00 && ry >= nr[k]);
        if (m_err[k]) return;
        a  = m_regs[k][rx];
        b  = ins[0] ? 64'(ins[12:5]) : m_regs[k][ry];
        sw = 0;
        while ((1 << sw) < dw[k]) sw++;
        sh = int'(b % (64'd1 << sw));
        c  = 1'b0;
        case (op)
            0: begin r = a + b; c = (r > mask); end
            1: begin r = a - b; c = (a < b); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a << sh;
            6: r = a >> sh;
            default: r = (a == b) ? 64'd0 : ((a > b) ? 64'd1 : 64'd2);
        endcase
        r = r & mask;
        m_regs[k][rx] = r;
        m_res[k] = r;
        m_z[k]   = (r == 0);
        m_c[k]   = c;
    endtask

    task automatic check_retire(input string tag);
        chk({tag, " done_a"}, 64'(done_a), 64'(1));
        chk({tag, " err_a"},  64'(err_a),  64'(m_err[0]));
        chk({tag, " res_a"},  64'(res_a),  m_res[0]);
        chk({tag, " z_a"},    64'(z_a),    64'(m_z[0]));
        chk({tag, " c_a"},    64'(c_a),    64'(m_c[0]));
        chk({tag, " done_b"}, 64'(done_b), 64'(1));
        chk({tag, " err_b"},  64'(err_b),  64'(m_err[1]));
        chk({tag, " res_b"},  64'(res_b),  m_res[1]);
        chk({tag, " z_b"},    64'(z_b),    64'(m_z[1]));
        chk({tag, " c_b"},    64'(c_b),    64'(m_c[1]));
    endtask

    task automatic check_dbg(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            chk({tag, " dbg_a"}, 64'(dbg_a), m_regs[0][i]);
            chk({tag, " dbg_b"}, 64'(dbg_b), (i >= nr[1]) ? 64'd0 : m_regs[1][i]);
        end
    endtask

    // Issue one instruction from a negedge in IDLE; ends at the negedge of done
    task automatic run_instr(input string tag, input logic [15:0] ins);
        chk({tag, " ready_a"}, 64'(rdy_a), 64'(1));
        chk({tag, " ready_b"}, 64'(rdy_b), 64'(1));
        model_exec(0, ins);
        model_exec(1, ins);
        instr       = ins;
        instr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            instr       = 16'($urandom);
            instr_valid = (k < 2);
            if (k < 3) begin
                chk({tag, " busy done"},  64'({done_a, done_b}), 64'(0));
                chk({tag, " busy ready"}, 64'({rdy_a, rdy_b}),   64'(0));
            end else begin
                chk({tag, " ready back"}, 64'({rdy_a, rdy_b}), 64'(3));
                check_retire(tag);
            end
        end
        instr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        logic [15:0] ins;

        rst_n = 1'b0; instr_valid = 1'b0; instr = '0; dbg_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst ready", 64'({rdy_a, rdy_b}), 64'(3));
        chk("rst done",  64'({done_a, done_b, err_a, err_b}), 64'(0));
        chk("rst res",   64'({res_a, res_b}), 64'(0));
        chk("rst flags", 64'({z_a, c_a, z_b, c_b}), 64'(0));
        rst_n = 1'b1;
        check_dbg("rst");

        // Load and accumulate
        run_instr("ld r1", mk_i(ALU_ADD, 3'd1, 8'd5));
        run_instr("add r1", mk_i(ALU_ADD, 3'd1, 8'd3));
        chk("add r1 lit", 64'(res_a), 64'h8);
        dbg_addr = 3'd1; #1;
        chk("dbg r1 lit", 64'(dbg_a), 64'h8);

        // Wrap-around carry/borrow
        run_instr("dec r2", mk_i(ALU_SUB, 3'd2, 8'd1));
        run_instr("wrap r2", mk_i(ALU_ADD, 3'd2, 8'd1));
        chk("wrap lit", 64'({res_a, z_a, c_a}), {46'd0, 16'h0000, 2'b11});
        run_instr("ld r3", mk_i(ALU_ADD, 3'd3, 8'd2));
        run_instr("ld r4", mk_i(ALU_ADD, 3'd4, 8'd3));
        run_instr("sub r3", mk_r(ALU_SUB, 3'd3, 3'd4));
        chk("borrow lit", 64'({res_a, c_a}), {47'd0, 16'hFFFF, 1'b1});

        // Compare and shifts (ry=5 is illegal on the 4-register core)
        run_instr("ld r0", mk_i(ALU_ADD, 3'd0, 8'd7));
        run_instr("ld r5", mk_i(ALU_ADD, 3'd5, 8'd9));
        run_instr("cmp", mk_r(ALU_CMP, 3'd0, 3'd5));
        chk("cmp lit", 64'({res_a, err_b}), {47'd0, 16'h0002, 1'b1});
        run_instr("clr r0", mk_i(ALU_AND, 3'd0, 8'd0));
        run_instr("ld7 r0", mk_i(ALU_ADD, 3'd0, 8'd7));
        run_instr("shl4", mk_i(ALU_SHL, 3'd0, 8'd4));
        chk("shl4 lit", 64'(res_a), 64'h70);
        run_instr("shl9", mk_i(ALU_SHL, 3'd0, 8'd9));
        chk("shl9 lit", 64'({res_a, res_b}), {40'd0, 16'hE000, 8'hE0});

        // rx=6 is legal for 8 registers, illegal for 4
        run_instr("rx6", mk_i(ALU_ADD, 3'd6, 8'd1));
        chk("rx6 err lit", 64'({err_a, err_b, res_b}), {54'd0, 2'b01, 8'hE0});
        run_instr("rr same", mk_r(ALU_ADD, 3'd1, 3'd1));
        check_dbg("dir");

        // Valid held high: only IDLE cycles accept
        acc = 0;
        for (int c = 0; c <= 12; c++) begin
            chk("burst ready", 64'({rdy_a, rdy_b}), (c % 4 == 0) ? 64'(3) : 64'(0));
            chk("burst done",  64'({done_a, done_b}), (c > 0 && c % 4 == 0) ? 64'(3) : 64'(0));
            if (c > 0 && c % 4 == 0) check_retire("burst");
            if (c < 10) begin
                ins = rnd_instr();
                instr = ins;
                instr_valid = 1'b1;
                if (rdy_a) acc++;
                if (c % 4 == 0) begin
                    model_exec(0, ins);
                    model_exec(1, ins);
                end
            end else begin
                instr_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk("burst accepts", 64'(acc), 64'(3));
        check_dbg("burst");

        // Random instruction stream
        for (int n = 0; n < 48; n++) run_instr("rnd", rnd_instr());
        check_dbg("rnd");

        // Reset during EXEC aborts the instruction
        instr = mk_i(ALU_ADD, 3'd1, 8'd1);
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort done0", 64'({done_a, done_b}), 64'(0));
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("abort done1", 64'({done_a, done_b}), 64'(0));
        chk("abort ready", 64'({rdy_a, rdy_b}), 64'(3));
        chk("abort res",   64'({res_a, res_b, z_a, c_a, z_b, c_b}), 64'(0));
        check_dbg("abort");
        run_instr("post rst", mk_i(ALU_ADD, 3'd1, 8'd5));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
